// File: rtl/io_timer_device_pkg.sv
// Shared types and register map for the memory-mapped interval timer.
// Register indices are word offsets (io_address[4:2]) within the timer window.
package io_timer_device_pkg;

  typedef logic [31:0] scalar_t;

  localparam logic [2:0] TIMER_CONTROL  = 3'd0;
  localparam logic [2:0] TIMER_RELOAD   = 3'd1;
  localparam logic [2:0] TIMER_COUNT    = 3'd2;
  localparam logic [2:0] TIMER_STATUS   = 3'd3;
  localparam logic [2:0] TIMER_PRESCALE = 3'd4;

  localparam int CTRL_EN          = 0;
  localparam int CTRL_AUTO_RELOAD = 1;
  localparam int CTRL_IRQ_EN      = 2;

  // Field order places en at bit 0, matching the CONTROL register layout.
  typedef struct packed {
    logic irq_en;
    logic auto_reload;
    logic en;
  } timer_control_t;

endpackage

// File: rtl/io_timer_device_prescaler.sv
// Tick divider for the interval timer: one tick every divisor+1 enabled cycles.
// Only instantiated when TIMER_PRESCALER_EN is defined.
module io_timer_prescaler (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        clear,
  input  logic [15:0] divisor,
  output logic        tick
);

  logic [15:0] count_reg;
  logic [15:0] count_next;

  assign tick = enable && (count_reg == divisor);

  always_comb begin
    count_next = count_reg;
    if (clear || tick) begin
      count_next = '0;
    end else if (enable) begin
      count_next = count_reg + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/io_timer_device.sv
// Memory-mapped interval timer on the non-cacheable IO bus, driving interrupt_req.
// Optional PRESCALE register and 32-byte window when TIMER_PRESCALER_EN is defined.
module io_timer_device
  import io_timer_device_pkg::*;
#(
  parameter scalar_t BASE_ADDRESS  = 32'hffff0100,
  parameter int      COUNTER_WIDTH = 32
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    io_write_en,
  input  logic    io_read_en,
  input  scalar_t io_address,
  input  scalar_t io_write_data,
  output scalar_t io_read_data,
  output logic    interrupt_req
);

`ifdef TIMER_PRESCALER_EN
  localparam int WIN_LSB = 5;
`else
  localparam int WIN_LSB = 4;
`endif

  localparam logic [COUNTER_WIDTH-1:0] COUNT_ONE = 1;

  timer_control_t           ctrl_reg, ctrl_next;
  logic [COUNTER_WIDTH-1:0] reload_reg, reload_next;
  logic [COUNTER_WIDTH-1:0] count_reg, count_next;
  logic                     pending_reg, pending_next;
  scalar_t                  read_data_reg, read_data_next;
  scalar_t                  read_value;
  logic                     irq_reg;
  logic                     hit;
  logic                     wr_hit;
  logic [2:0]               reg_sel;
  logic                     tick;
  logic                     unused_bits;

  assign hit         = (io_address[31:WIN_LSB] == BASE_ADDRESS[31:WIN_LSB]);
  assign reg_sel     = io_address[4:2];
  assign wr_hit      = io_write_en && hit;
  assign unused_bits = ^{io_address[1:0], io_write_data};

`ifdef TIMER_PRESCALER_EN
  logic [15:0] prescale_reg, prescale_next;
  logic        prescale_clear;

  assign prescale_clear = wr_hit && ((reg_sel == TIMER_CONTROL) || (reg_sel == TIMER_PRESCALE));

  io_timer_prescaler u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .enable  (ctrl_reg.en),
    .clear   (prescale_clear),
    .divisor (prescale_reg),
    .tick    (tick)
  );
`else
  assign tick = ctrl_reg.en;
`endif

  always_comb begin
    read_value = '0;
    case (reg_sel)
      TIMER_CONTROL:  read_value[2:0] = ctrl_reg;
      TIMER_RELOAD:   read_value[COUNTER_WIDTH-1:0] = reload_reg;
      TIMER_COUNT:    read_value[COUNTER_WIDTH-1:0] = count_reg;
      TIMER_STATUS:   read_value[0] = pending_reg;
`ifdef TIMER_PRESCALER_EN
      TIMER_PRESCALE: read_value[15:0] = prescale_reg;
`endif
      default:        read_value = '0;
    endcase
    read_data_next = (io_read_en && hit) ? read_value : '0;
  end

  // Tick effects first, then CPU writes override them; a pending set beats a clear.
  always_comb begin
    ctrl_next    = ctrl_reg;
    reload_next  = reload_reg;
    count_next   = count_reg;
    pending_next = pending_reg;
`ifdef TIMER_PRESCALER_EN
    prescale_next = prescale_reg;
`endif
    if (tick) begin
      if (count_reg != '0) begin
        count_next = count_reg - COUNT_ONE;
      end else if (ctrl_reg.auto_reload) begin
        count_next = reload_reg;
      end else begin
        ctrl_next.en = 1'b0;
      end
    end
    if (wr_hit) begin
      case (reg_sel)
        TIMER_CONTROL:  ctrl_next   = timer_control_t'(io_write_data[2:0]);
        TIMER_RELOAD:   reload_next = io_write_data[COUNTER_WIDTH-1:0];
        TIMER_COUNT:    count_next  = io_write_data[COUNTER_WIDTH-1:0];
        TIMER_STATUS:   if (io_write_data[0]) pending_next = 1'b0;
`ifdef TIMER_PRESCALER_EN
        TIMER_PRESCALE: prescale_next = io_write_data[15:0];
`endif
        default:        ;
      endcase
    end
    if (tick && (count_reg == '0)) begin
      pending_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_reg      <= '0;
      reload_reg    <= '0;
      count_reg     <= '0;
      pending_reg   <= 1'b0;
      read_data_reg <= '0;
      irq_reg       <= 1'b0;
`ifdef TIMER_PRESCALER_EN
      prescale_reg  <= '0;
`endif
    end else begin
      ctrl_reg      <= ctrl_next;
      reload_reg    <= reload_next;
      count_reg     <= count_next;
      pending_reg   <= pending_next;
      read_data_reg <= read_data_next;
      irq_reg       <= pending_reg && ctrl_reg.irq_en;
`ifdef TIMER_PRESCALER_EN
      prescale_reg  <= prescale_next;
`endif
    end
  end

  assign io_read_data  = read_data_reg;
  assign interrupt_req = irq_reg;

endmodule

// File: tb/tb_io_timer_device.sv
// Self-checking bench for io_timer_device: per-cycle model comparison plus literal checks.
// Honours TIMER_PRESCALER_EN the same way as the design.
module tb_io_timer_device;
  import io_timer_device_pkg::*;

  localparam logic [31:0] BASE = 32'hffff0100;
`ifdef TIMER_PRESCALER_EN
  localparam logic [31:0] WIN = 32'd32;
`else
  localparam logic [31:0] WIN = 32'd16;
`endif

  logic    clk = 1'b0;
  logic    reset = 1'b1;
  logic    io_write_en = 1'b0;
  logic    io_read_en = 1'b0;
  scalar_t io_address = '0;
  scalar_t io_write_data = '0;
  scalar_t io_read_data;
  logic    interrupt_req;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  io_timer_device #(.BASE_ADDRESS(BASE), .COUNTER_WIDTH(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .io_write_en   (io_write_en),
    .io_read_en    (io_read_en),
    .io_address    (io_address),
    .io_write_data (io_write_data),
    .io_read_data  (io_read_data),
    .interrupt_req (interrupt_req)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural model: register file as plain variables, advanced once per clock.
  bit          m_en = 0, m_auto = 0, m_irqen = 0, m_pending = 0;
  logic [31:0] m_reload = 0, m_count = 0;
  logic [15:0] m_prescale = 0, m_pc = 0;
  logic [31:0] exp_rdata = 0;
  bit          exp_irq = 0;
  bit          m_hit, m_tick, m_w, m_set, m_en_old;
  int          m_idx;

  function automatic logic [31:0] m_reg(input int idx);
    case (idx)
      0: return {29'd0, m_irqen, m_auto, m_en};
      1: return m_reload;
      2: return m_count;
      3: return {31'd0, m_pending};
`ifdef TIMER_PRESCALER_EN
      4: return {16'd0, m_prescale};
`endif
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_en = 0; m_auto = 0; m_irqen = 0; m_pending = 0;
      m_reload = 0; m_count = 0; m_prescale = 0; m_pc = 0;
      exp_rdata = 0; exp_irq = 0;
    end else begin
      m_hit = ((io_address & ~(WIN - 1)) == BASE);
      m_idx = int'((io_address & (WIN - 1)) >> 2);
      exp_rdata = (io_read_en && m_hit) ? m_reg(m_idx) : 32'd0;
      exp_irq = m_pending && m_irqen;
      m_en_old = m_en;
`ifdef TIMER_PRESCALER_EN
      m_tick = m_en && (m_pc == m_prescale);
`else
      m_tick = m_en;
`endif
      m_w = io_write_en && m_hit;
      m_set = m_tick && (m_count == 0);
      if (m_tick) begin
        if (m_count != 0) m_count = m_count - 1;
        else if (m_auto) m_count = m_reload;
        else m_en = 0;
      end
`ifdef TIMER_PRESCALER_EN
      if (m_w && (m_idx == 0 || m_idx == 4)) m_pc = 0;
      else if (m_tick) m_pc = 0;
      else if (m_en_old) m_pc = m_pc + 1;
`endif
      if (m_w) begin
        case (m_idx)
          0: {m_irqen, m_auto, m_en} = io_write_data[2:0];
          1: m_reload = io_write_data;
          2: m_count = io_write_data;
          3: if (io_write_data[0]) m_pending = 0;
`ifdef TIMER_PRESCALER_EN
          4: m_prescale = io_write_data[15:0];
`endif
          default: ;
        endcase
      end
      if (m_set) m_pending = 1;
    end
  end

  always @(negedge clk) begin
    checks += 2;
    if (io_read_data !== exp_rdata) begin
      failures++;
      $display("FAIL model_rdata cyc=%0d got=%h want=%h", cyc, io_read_data, exp_rdata);
    end
    if (interrupt_req !== exp_irq) begin
      failures++;
      $display("FAIL model_irq cyc=%0d got=%b want=%b", cyc, interrupt_req, exp_irq);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end else begin
      $display("ok   %s = %h", name, got);
    end
  endtask

  // All bus tasks start and end 2 time units after a rising edge.
  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    io_write_en = 1'b1; io_address = addr; io_write_data = data;
    @(posedge clk); #2;
    io_write_en = 1'b0; io_address = '0; io_write_data = '0;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] want, input string name);
    io_read_en = 1'b1; io_address = addr;
    @(posedge clk); #2;
    io_read_en = 1'b0; io_address = '0;
    check(name, io_read_data, want);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  // Cycles until interrupt_req reaches level; limit+1 when the bound expires.
  task automatic wait_irq(input bit level, input int limit, output int n);
    n = 0;
    while (n <= limit) begin
      @(posedge clk); #2;
      n++;
      if (interrupt_req == level) break;
    end
  endtask

  int n;
  int t_prev, t_now;

  initial begin
    #1 reset = 1'b0;
    idle(2);
    reset = 1'b1;
    idle(1);

    check("irq_after_reset", {31'd0, interrupt_req}, 32'd0);
    rd(BASE + 32'h0, 32'd0, "reset_control");
    rd(BASE + 32'h4, 32'd0, "reset_reload");
    rd(BASE + 32'h8, 32'd0, "reset_count");
    rd(BASE + 32'hC, 32'd0, "reset_status");

    // One-shot: COUNT=3 -> pending on 4th tick, irq one cycle later.
    wr(BASE + 32'h8, 32'd3);
    wr(BASE + 32'h0, 32'h5);
    wait_irq(1'b1, 50, n);
    check("oneshot_irq_latency", n, 32'd5);
    rd(BASE + 32'h0, 32'h4, "oneshot_control");
    rd(BASE + 32'h8, 32'd0, "oneshot_count");
    rd(BASE + 32'hC, 32'd1, "oneshot_status");
    wr(BASE + 32'hC, 32'd1);
    wait_irq(1'b0, 2, n);
    check("oneshot_irq_drop", n, 32'd1);

    // Auto-reload: period of 10 ticks, cleared after every interrupt.
    wr(BASE + 32'h4, 32'd9);
    wr(BASE + 32'h8, 32'd9);
    wr(BASE + 32'h0, 32'h7);
    wait_irq(1'b1, 50, n);
    check("auto_first_latency", n, 32'd11);
    t_prev = cyc;
    for (int k = 0; k < 3; k++) begin
      wr(BASE + 32'hC, 32'd1);
      wait_irq(1'b0, 2, n);
      check("auto_irq_drop", n, 32'd1);
      wait_irq(1'b1, 30, n);
      t_now = cyc;
      check("auto_period", t_now - t_prev, 32'd10);
      t_prev = t_now;
    end

    // Read and write of RELOAD in one cycle returns the old value.
    io_write_en = 1'b1; io_read_en = 1'b1; io_address = BASE + 32'h4; io_write_data = 32'hAB;
    @(posedge clk); #2;
    io_write_en = 1'b0; io_read_en = 1'b0; io_address = '0; io_write_data = '0;
    check("rw_same_cycle", io_read_data, 32'd9);
    rd(BASE + 32'h4, 32'hAB, "rw_new_reload");

    // COUNT write during a tick wins over the decrement.
    wr(BASE + 32'h8, 32'd100);
    rd(BASE + 32'h8, 32'd100, "count_write_collision");

    // STATUS clear on the COUNT==0 tick leaves PENDING set.
    wr(BASE + 32'h0, 32'h0);
    wr(BASE + 32'hC, 32'd1);
    wr(BASE + 32'h8, 32'd2);
    wr(BASE + 32'h0, 32'h1);
    idle(2);
    wr(BASE + 32'hC, 32'd1);
    rd(BASE + 32'hC, 32'd1, "clear_collision_status");
    rd(BASE + 32'h0, 32'd0, "clear_collision_control");

    // Decode: misses are dropped and read 0; bits [1:0] are ignored.
    wr(BASE + 32'h8, 32'h1234);
    wr(BASE + 32'h48, 32'h55);
    rd(BASE + 32'h48, 32'd0, "miss_high_read");
    wr(BASE + 32'h40, 32'h7);
    wr(32'h0000_0008, 32'h66);
    rd(32'h0000_0008, 32'd0, "miss_low_read");
    rd(BASE + 32'h8, 32'h1234, "miss_no_change");
    rd(BASE + 32'h0, 32'd0, "miss_control_intact");
    rd(BASE + 32'hA, 32'h1234, "alias_count");

`ifdef TIMER_PRESCALER_EN
    wr(BASE + 32'hC, 32'd1);
    wr(BASE + 32'h10, 32'd3);
    wr(BASE + 32'h8, 32'd1);
    wr(BASE + 32'h0, 32'h5);
    wait_irq(1'b1, 50, n);
    check("prescale_irq_latency", n, 32'd9);
    rd(BASE + 32'h10, 32'd3, "prescale_read");
`else
    wr(BASE + 32'h10, 32'd3);
    rd(BASE + 32'h10, 32'd0, "offset10_unmapped");
`endif

    // Reset mid-count with a read in flight.
    wr(BASE + 32'h4, 32'd50);
    wr(BASE + 32'h8, 32'd50);
    wr(BASE + 32'h0, 32'h7);
    idle(3);
    io_read_en = 1'b1; io_address = BASE + 32'h8;
    reset = 1'b0;
    @(posedge clk); #2;
    check("reset_inflight_read", io_read_data, 32'd0);
    check("reset_irq", {31'd0, interrupt_req}, 32'd0);
    io_read_en = 1'b0; io_address = '0;
    reset = 1'b1;
    idle(1);
    rd(BASE + 32'h0, 32'd0, "post_reset_control");
    rd(BASE + 32'h8, 32'd0, "post_reset_count");
    rd(BASE + 32'h4, 32'd0, "post_reset_reload");

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/io_timer_device.md
Name: io_timer_device

Overview:
- Memory-mapped interval timer that responds on the processor's non-cacheable IO bus (io_write_en/io_read_en/io_address/io_write_data/io_read_data).
- Drives the processor's interrupt_req input.
- Sits at SoC level beside the processor top: the responder end of the IO bus, and the source end of the interrupt line.

Parameters:
- BASE_ADDRESS, 32'hffff0100: 16-byte-aligned base of the register window (32 bytes when PRESCALER_EN is defined).
- COUNTER_WIDTH, 32: width of the COUNT and RELOAD registers, 1..32; upper bits read as 0.

Ports:
- clk, input, 1: clock.
- reset, input, 1: asynchronous, active-low reset (asserted when 0).
- io_write_en, input, 1: single-cycle write strobe.
- io_read_en, input, 1: single-cycle read strobe.
- io_address, input, 32 (scalar_t): byte address.
- io_write_data, input, 32 (scalar_t): write data.
- io_read_data, output, 32 (scalar_t): read data, registered.
- interrupt_req, output, 1: level interrupt to processor, registered.

Behaviour:
- Select: hit = io_address[31:5 or 31:4] matches BASE_ADDRESS; register = io_address[4:2]. Bits [1:0] are ignored. No access is ever stalled.
- Register map (offsets):
  - 0x00 CONTROL, RW: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN; other bits read 0.
  - 0x04 RELOAD, RW.
  - 0x08 COUNT, RW.
  - 0x0C STATUS, R: bit0 PENDING. Writing 1 to bit0 clears PENDING.
- Read latency is exactly 1 cycle: io_read_data is registered on the cycle io_read_en is high.
  - On a hit, it holds the addressed register. On a miss or unmapped offset, it is 0.
  - It is 0 in every cycle with no read, so external decode may OR several devices together.
- Writes take effect at the clock edge of the io_write_en cycle. Writes to a miss or unmapped offset are dropped. Read and write in the same cycle: the read returns the pre-write value.
- Tick: occurs every cycle while EN=1 (see Optional Feature for the prescaled case).
- On a tick:
  - If COUNT != 0: COUNT <= COUNT-1.
  - If COUNT == 0: PENDING <= 1. Then, if AUTO_RELOAD, COUNT <= RELOAD; otherwise EN <= 0 and COUNT stays 0.
  - Period = RELOAD+1 ticks.
- Simultaneous events:
  - CPU write to COUNT in a tick cycle: the write wins and no decrement occurs.
  - CPU write to CONTROL in a tick cycle: the written EN wins.
  - STATUS clear in the same cycle PENDING is set: set wins.
- interrupt_req <= PENDING & IRQ_EN, registered, so it rises 1 cycle after PENDING.
- Reset (any time, including mid-count): all registers 0, io_read_data 0, interrupt_req 0. Any in-flight read returns 0.
- Arithmetic: COUNT decrement never underflows, because the zero case is handled explicitly.

Optional Feature:
- Macro: TIMER_PRESCALER_EN.
- Defined:
  - Adds 0x10 PRESCALE, RW, 16 bits, and a 16-bit prescale counter.
  - A tick occurs when EN=1 and the prescale counter == PRESCALE. The prescale counter then resets to 0; otherwise it increments while EN=1.
  - Any write to CONTROL or PRESCALE clears the prescale counter.
  - Tick period = PRESCALE+1 cycles.
- Undefined:
  - Tick every cycle while EN=1.
  - 0x10 is unmapped and reads 0.
  - The window is 16 bytes.

Decomposition:
- defines.sv gets the register offset constants (TIMER_CONTROL..TIMER_PRESCALE), CONTROL bit indices, and a timer_control_t packed struct.
- Reuses scalar_t.
- One sub-module, io_timer_prescaler: clk, reset, enable, clear, divisor -> tick. Instantiated only under TIMER_PRESCALER_EN; otherwise tick = EN.

Test Plan:
- Reset state: after reset, read 0x00/0x04/0x08/0x0C -> io_read_data 0 one cycle after each read. interrupt_req = 0.
- One-shot:
  - Stimulus: write COUNT=3, then CONTROL=0x5.
  - PENDING sets on the 4th tick and interrupt_req rises 1 cycle later.
  - CONTROL reads 0x4; COUNT reads 0.
- Auto-reload and clear:
  - Stimulus: RELOAD=9, COUNT=9, CONTROL=0x7; clear STATUS after each interrupt.
  - Interrupts arrive every 10 cycles.
  - Writing STATUS=1 drops interrupt_req within 2 cycles.
- Collision:
  - A STATUS clear coinciding with the COUNT==0 tick leaves PENDING=1.
  - A write COUNT=100 coinciding with a tick reads back 100 on the next read.
- Decode:
  - Read/write at BASE_ADDRESS+0x40 and at 0x00000008 -> read data 0, no register changes.
  - Read at BASE_ADDRESS+0x0A aliases COUNT.
- Prescaler (TIMER_PRESCALER_EN):
  - Stimulus: PRESCALE=3, COUNT=1, CONTROL=0x5.
  - PENDING sets after 8 cycles. Without the macro, 0x10 reads 0.
